// File: rtl/axis_demux_pkg.sv
// Shared encodings for the packet-atomic 1:2 AXI-Stream demux.
package axis_demux_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    localparam logic DEST_M0   = 1'b0;
    localparam logic DEST_M1   = 1'b1;
    localparam int   PKT_CNT_W = 16;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register: loads a beat on request and holds it
// until the downstream handshake drains it.
module axis_out_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last
);

    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  last_reg;

    // A load wins over a drain, so a same-cycle drain+load keeps valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            last_reg  <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
            last_reg  <= load_last;
        end else if (ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
    assign last  = last_reg;

endmodule

// File: rtl/axis_demux_1to2.sv
// Packet-atomic 1:2 AXI-Stream router with the route latched per packet.
// Optional per-port packet counters are enabled with AXIS_DEMUX_PKT_CNT_EN.
module axis_demux_1to2
    import axis_demux_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 14,
    parameter int INT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m0_tdata,
    output logic                  m0_tvalid,
    output logic                  m0_tlast,
    input  logic                  m0_tready,
    output logic [DATA_WIDTH-1:0] m1_tdata,
    output logic                  m1_tvalid,
    output logic                  m1_tlast,
    input  logic                  m1_tready
`ifdef AXIS_DEMUX_PKT_CNT_EN
    ,
    output logic [PKT_CNT_W-1:0]  pkt_cnt0,
    output logic [PKT_CNT_W-1:0]  pkt_cnt1
`endif
);

    // The register width comes from the Q-format split, so an inconsistent
    // DATA_WIDTH shows up as a port width mismatch at elaboration.
    localparam int BEAT_W = INT_WIDTH + FRAC_WIDTH;

    state_t                state_reg;
    logic                  dest_reg;
    logic                  eff_dest;
    logic                  accept;
    logic [1:0]            load;
    logic [1:0]            out_ready;
    logic [1:0]            out_valid;
    logic [1:0]            out_last;
    logic [DATA_WIDTH-1:0] out_data [2];

    assign eff_dest  = (state_reg == ST_IN_PKT) ? dest_reg : sel;
    assign out_ready = {m1_tready, m0_tready};

    // Ready follows only the port in use, so a stalled idle port never blocks.
    assign s_tready = (eff_dest == DEST_M1) ? (~out_valid[1] | out_ready[1])
                                            : (~out_valid[0] | out_ready[0]);
    assign accept   = s_tvalid & s_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            dest_reg  <= DEST_M0;
        end else if (accept) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!s_tlast) begin
                        state_reg <= ST_IN_PKT;
                        dest_reg  <= sel;
                    end
                end
                ST_IN_PKT: begin
                    if (s_tlast) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_out
        assign load[gi] = accept & (eff_dest == 1'(gi));

        axis_out_reg #(
            .DATA_WIDTH (BEAT_W)
        ) u_out_reg (
            .clk       (clk),
            .reset     (reset),
            .load      (load[gi]),
            .load_data (s_tdata),
            .load_last (s_tlast),
            .ready     (out_ready[gi]),
            .valid     (out_valid[gi]),
            .data      (out_data[gi]),
            .last      (out_last[gi])
        );
    end

    assign m0_tdata  = out_data[0];
    assign m0_tvalid = out_valid[0];
    assign m0_tlast  = out_last[0];
    assign m1_tdata  = out_data[1];
    assign m1_tvalid = out_valid[1];
    assign m1_tlast  = out_last[1];

`ifdef AXIS_DEMUX_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] pkt_cnt0_reg;
    logic [PKT_CNT_W-1:0] pkt_cnt1_reg;

    // Counters wrap naturally at 2^PKT_CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt0_reg <= '0;
            pkt_cnt1_reg <= '0;
        end else begin
            if (out_valid[0] & out_ready[0] & out_last[0]) begin
                pkt_cnt0_reg <= pkt_cnt0_reg + PKT_CNT_W'(1);
            end
            if (out_valid[1] & out_ready[1] & out_last[1]) begin
                pkt_cnt1_reg <= pkt_cnt1_reg + PKT_CNT_W'(1);
            end
        end
    end

    assign pkt_cnt0 = pkt_cnt0_reg;
    assign pkt_cnt1 = pkt_cnt1_reg;
`endif

endmodule
